// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Data-side bus controller behind the processor Memory stage. Turns a
//   single-word load/store request into a registered req/ack memory access,
//   stalls the pipeline via DataWaitreq, returns load data on DataIn and
//   aborts hung accesses after TIMEOUT cycles, raising a sticky BusError.
//
// Ports
//   Clock, Reset          : clock, asynchronous active-high reset
//   DataAddr, DataOut     : processor word address / store data
//   ReadData, WriteData   : load / store request (both high = store)
//   DataIn                : registered load result
//   DataWaitreq           : combinational stall to the processor
//   MemAddr, MemWdata     : registered memory address / write data
//   MemWe, MemReq         : registered write enable / access request
//   MemRdata, MemAck      : memory read data / access complete
//   BusError, ErrClear    : sticky timeout flag / its clear
module data_mem_ctrl #(
  parameter int                   WORD_SIZE = 16,
  parameter int                   TIMEOUT   = 15,
  parameter logic [WORD_SIZE-1:0] ERR_DATA  = 16'hDEAD
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic [WORD_SIZE-1:0] MemWdata,
  output logic                 MemWe,
  output logic                 MemReq,
  input  logic [WORD_SIZE-1:0] MemRdata,
  input  logic                 MemAck,
  output logic                 BusError,
  input  logic                 ErrClear
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  // Timer counts completed ACCESS cycles; it is compared, never wraps.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e               state_q,   state_d;
  logic [WORD_SIZE-1:0] datain_q,  datain_d;
  logic [WORD_SIZE-1:0] addr_q,    addr_d;
  logic [WORD_SIZE-1:0] wdata_q,   wdata_d;
  logic                 we_q,      we_d;
  logic                 memreq_q,  memreq_d;
  logic                 buserr_q,  buserr_d;
  logic [7:0]           timer_q,   timer_d;
  logic                 req;
  logic                 timeout;

  assign req = ReadData | WriteData;

  always_comb begin
    state_d  = state_q;
    datain_d = datain_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    memreq_d = memreq_q;
    timer_d  = timer_q;
    timeout  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d   = DataAddr;
          wdata_d  = DataOut;
          we_d     = WriteData;
          memreq_d = 1'b1;
          timer_d  = '0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        // An ack in the final allowed cycle takes priority over the timeout.
        if (MemAck) begin
          if (!we_q) datain_d = MemRdata;
          memreq_d = 1'b0;
          state_d  = DONE;
        end else if (timer_q == TIMER_LAST) begin
          if (!we_q) datain_d = ERR_DATA;
          timeout  = 1'b1;
          memreq_d = 1'b0;
          state_d  = DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Set wins over clear when both happen in the same cycle.
    if (timeout)       buserr_d = 1'b1;
    else if (ErrClear) buserr_d = 1'b0;
    else               buserr_d = buserr_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      datain_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      memreq_q <= 1'b0;
      buserr_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      datain_q <= datain_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      memreq_q <= memreq_d;
      buserr_q <= buserr_d;
      timer_q  <= timer_d;
    end
  end

  assign DataWaitreq = req && (state_q != DONE);
  assign DataIn      = datain_q;
  assign MemAddr     = addr_q;
  assign MemWdata    = wdata_q;
  assign MemWe       = we_q;
  assign MemReq      = memreq_q;
  assign BusError    = buserr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam int TO = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] DataAddr, DataOut, DataIn, MemAddr, MemWdata, MemRdata;
  logic        ReadData, WriteData, DataWaitreq, MemWe, MemReq, MemAck;
  logic        BusError, ErrClear;

  int total = 0;
  int bad   = 0;

  // Transaction-level expectations for the sticky outputs.
  logic [15:0] m_datain;
  logic        m_buserr;

  data_mem_ctrl #(.WORD_SIZE(16), .TIMEOUT(TO), .ERR_DATA(16'hDEAD)) dut (
    .Clock(Clock), .Reset(Reset),
    .DataAddr(DataAddr), .DataOut(DataOut),
    .ReadData(ReadData), .WriteData(WriteData),
    .DataIn(DataIn), .DataWaitreq(DataWaitreq),
    .MemAddr(MemAddr), .MemWdata(MemWdata), .MemWe(MemWe), .MemReq(MemReq),
    .MemRdata(MemRdata), .MemAck(MemAck),
    .BusError(BusError), .ErrClear(ErrClear)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access from its IDLE cycle (c=0) through DONE. k = ack delay in
  // cycles after MemReq rises, negative or >= TO means no ack (timeout).
  // Entered and left just after a rising edge.
  task automatic run_access(input bit wr, input bit rd, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] rdata,
                            input int k, input bit drop, input bit clr_last);
    bit acked;
    int last_req, done_c;
    bit req_now;
    acked    = (k >= 0) && (k < TO);
    last_req = acked ? 1 + k : TO;
    done_c   = last_req + 1;
    DataAddr = addr; DataOut = wdata; WriteData = wr; ReadData = rd;
    for (int c = 0; c <= done_c; c++) begin
      if (drop && c == 2) begin ReadData = 1'b0; WriteData = 1'b0; end
      MemAck   = acked && (c == 1 + k);
      MemRdata = MemAck ? rdata : 16'($urandom);
      ErrClear = clr_last && !acked && (c == TO);
      @(negedge Clock);
      req_now = ReadData | WriteData;
      chk("waitreq", 16'(DataWaitreq), 16'(req_now && (c != done_c)));
      chk("memreq",  16'(MemReq),      16'(c >= 1 && c <= last_req));
      if (c >= 1 && c <= last_req) begin
        chk("memaddr", MemAddr, addr);
        chk("memwe",   16'(MemWe), 16'(wr));
        if (wr) chk("memwdata", MemWdata, wdata);
      end
      if (c == done_c) begin
        if (!wr) m_datain = acked ? rdata : 16'hDEAD;
        if (!acked) m_buserr = 1'b1;
        chk("datain_done", DataIn, m_datain);
      end
      chk("buserr", 16'(BusError), 16'(m_buserr));
      @(posedge Clock); #1;
    end
    ReadData = 1'b0; WriteData = 1'b0; MemAck = 1'b0; ErrClear = 1'b0;
  endtask

  // A cycle with no request; optionally pulses ErrClear or a stray ack.
  task automatic idle_cycle(input bit clr, input bit stray_ack);
    ErrClear = clr; MemAck = stray_ack; MemRdata = 16'($urandom);
    @(negedge Clock);
    chk("idle_memreq",  16'(MemReq), 16'h0);
    chk("idle_waitreq", 16'(DataWaitreq), 16'h0);
    chk("idle_datain",  DataIn, m_datain);
    chk("idle_buserr",  16'(BusError), 16'(m_buserr));
    @(posedge Clock); #1;
    if (clr) m_buserr = 1'b0;
    ErrClear = 1'b0; MemAck = 1'b0;
  endtask

  initial begin
    int k;
    bit wr, rd, drop;
    Reset = 1'b1; ReadData = 1'b1; WriteData = 1'b0; DataAddr = 16'h1357;
    DataOut = 16'h2468; MemRdata = '0; MemAck = 1'b0; ErrClear = 1'b0;
    m_datain = '0; m_buserr = 1'b0;

    // Reset values; stall follows req while held in IDLE.
    @(negedge Clock); @(negedge Clock);
    chk("rst_datain",  DataIn, 16'h0);
    chk("rst_memaddr", MemAddr, 16'h0);
    chk("rst_memwdata", MemWdata, 16'h0);
    chk("rst_memwe",   16'(MemWe), 16'h0);
    chk("rst_memreq",  16'(MemReq), 16'h0);
    chk("rst_buserr",  16'(BusError), 16'h0);
    chk("rst_waitreq", 16'(DataWaitreq), 16'h1);
    ReadData = 1'b0;
    @(posedge Clock); #1 Reset = 1'b0;
    idle_cycle(0, 0);

    // Read, immediate ack.
    run_access(0, 1, 16'h0040, 16'h0000, 16'h1234, 0, 0, 0);
    idle_cycle(0, 0);
    // Write, ack 3 cycles after MemReq rises; DataIn must stay 1234.
    run_access(1, 0, 16'h0100, 16'hBEEF, 16'h5555, 3, 0, 0);
    idle_cycle(0, 0);
    // Timeout read, late ack ignored, then ErrClear.
    run_access(0, 1, 16'h0200, 16'h0000, 16'h0000, -1, 0, 0);
    idle_cycle(0, 1);
    idle_cycle(1, 0);
    idle_cycle(0, 0);
    // Ack in the last allowed ACCESS cycle.
    run_access(0, 1, 16'h0300, 16'h0000, 16'h00AA, TO - 1, 0, 0);
    // Back-to-back read then write (both-high request counts as write).
    run_access(0, 1, 16'h0400, 16'h0000, 16'h4321, 1, 0, 0);
    run_access(1, 1, 16'h0404, 16'hCAFE, 16'h9999, 0, 0, 0);
    idle_cycle(0, 0);

    // Reset asserted in the middle of ACCESS.
    DataAddr = 16'h0500; ReadData = 1'b1; MemAck = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b1;
    #1;
    chk("arst_memreq",  16'(MemReq), 16'h0);
    chk("arst_memaddr", MemAddr, 16'h0);
    chk("arst_datain",  DataIn, 16'h0);
    chk("arst_buserr",  16'(BusError), 16'h0);
    chk("arst_waitreq", 16'(DataWaitreq), 16'h1);
    m_datain = '0; m_buserr = 1'b0;
    ReadData = 1'b0;
    @(posedge Clock); #1 Reset = 1'b0;
    run_access(0, 1, 16'h0600, 16'h0000, 16'h7777, 0, 0, 0);
    idle_cycle(0, 0);
    // Timeout coinciding with ErrClear: set wins.
    run_access(0, 1, 16'h0700, 16'h0000, 16'h0000, -1, 0, 1);
    idle_cycle(0, 0);
    idle_cycle(1, 0);

    // Randomized accesses.
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom);
      rd   = wr ? 1'($urandom) : 1'b1;
      k    = int'($urandom_range(0, 5));
      if (k >= TO) k = -1;
      drop = ($urandom_range(0, 7) == 0);
      run_access(wr, rd, 16'($urandom), 16'($urandom), 16'($urandom), k, drop, 1'($urandom));
      if ($urandom_range(0, 2) != 0)
        idle_cycle($urandom_range(0, 3) == 0, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
